// File: rtl/deserializer_pkg.sv
// Shared word/bit-count types for the serial link (serializer, deserializer, benches).
package deser_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned MOD_W  = $clog2(DATA_W);

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [MOD_W-1:0]  mod_t;

endpackage

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel converter with early word termination.
// A word completes on the DATA_W-th valid bit or on a valid bit flagged last;
// the word and its bit count are presented one cycle later with a 1-cycle pulse.
module deserializer
  import deser_pkg::*;
(
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  input  logic              ser_last_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_mod_o,
  output logic              deser_data_val_o,
  output logic              busy_o
);

  localparam mod_t LAST_IDX = mod_t'(DATA_W - 1);

  word_t sh;
  mod_t  bit_cnt;

  mod_t  pos_c;
  mod_t  cnt_inc_c;
  word_t sh_ins_c;
  word_t keep_mask_c;
  logic  done_c;

  // Insert the incoming bit, detect word completion, and mask unfilled low bits.
  always_comb begin
    pos_c          = LAST_IDX - bit_cnt;
    cnt_inc_c      = bit_cnt + mod_t'(1);
    sh_ins_c       = sh;
    sh_ins_c[pos_c] = ser_data_i;
    keep_mask_c    = {DATA_W{1'b1}} << pos_c;
    done_c         = ser_data_val_i && (ser_last_i || (bit_cnt == LAST_IDX));
  end

  // Shift register, bit counter and registered word outputs; reset wins over completion.
  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      sh               <= '0;
      bit_cnt          <= '0;
      deser_data_o     <= '0;
      deser_mod_o      <= '0;
      deser_data_val_o <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      deser_data_val_o <= 1'b0;
      if (ser_data_val_i) begin
        if (done_c) begin
          // Bit count wraps to 0 for a full word, which is the intended encoding.
          deser_data_o     <= sh_ins_c & keep_mask_c;
          deser_mod_o      <= cnt_inc_c;
          deser_data_val_o <= 1'b1;
          sh               <= '0;
          bit_cnt          <= '0;
          busy_o           <= 1'b0;
        end else begin
          sh      <= sh_ins_c;
          bit_cnt <= cnt_inc_c;
          busy_o  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for the deserializer.
module tb_deserializer;
  import deser_pkg::*;

  logic              clk_i;
  logic              srst_i;
  logic              ser_data_i;
  logic              ser_data_val_i;
  logic              ser_last_i;
  logic [DATA_W-1:0] deser_data_o;
  logic [MOD_W-1:0]  deser_mod_o;
  logic              deser_data_val_o;
  logic              busy_o;

  int n_vec;
  int n_err;
  int pulse_cnt;

  deserializer dut (
    .clk_i            (clk_i),
    .srst_i           (srst_i),
    .ser_data_i       (ser_data_i),
    .ser_data_val_i   (ser_data_val_i),
    .ser_last_i       (ser_last_i),
    .deser_data_o     (deser_data_o),
    .deser_mod_o      (deser_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .busy_o           (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Count output pulses away from the active edge.
  always @(negedge clk_i) begin
    if (deser_data_val_o === 1'b1) pulse_cnt++;
  end

  // Present one valid bit for one clock, then sample #1 after the edge.
  task automatic drive_bit(input logic b, input logic lst);
    ser_data_i     = b;
    ser_data_val_i = 1'b1;
    ser_last_i     = lst;
    @(posedge clk_i);
    #1;
    ser_data_val_i = 1'b0;
    ser_last_i     = 1'b0;
  endtask

  // One clock with no valid bit (last may be set to prove it is ignored).
  task automatic idle(input logic lst);
    ser_data_val_i = 1'b0;
    ser_last_i     = lst;
    @(posedge clk_i);
    #1;
    ser_last_i     = 1'b0;
  endtask

  task automatic test_reset();
    srst_i = 1'b0;
    idle(1'b0);
    idle(1'b0);
    srst_i = 1'b1;
    n_vec++; if (deser_data_o !== 16'h0000) begin n_err++; $display("FAIL reset_data got %h exp 0000", deser_data_o); end
    n_vec++; if (deser_mod_o !== 4'd0) begin n_err++; $display("FAIL reset_mod got %0d exp 0", deser_mod_o); end
    n_vec++; if (deser_data_val_o !== 1'b0) begin n_err++; $display("FAIL reset_val got %b exp 0", deser_data_val_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_full_word();
    logic [15:0] w;
    int p0;
    w  = 16'hA5C3;
    p0 = pulse_cnt;
    for (int i = 0; i < 16; i++) begin
      drive_bit(w[15-i], 1'b0);
      n_vec++; if (deser_data_val_o !== (i == 15)) begin n_err++; $display("FAIL full_val bit %0d got %b exp %b", i, deser_data_val_o, (i == 15)); end
      n_vec++; if (busy_o !== (i != 15)) begin n_err++; $display("FAIL full_busy bit %0d got %b exp %b", i, busy_o, (i != 15)); end
    end
    n_vec++; if (deser_data_o !== 16'hA5C3) begin n_err++; $display("FAIL full_data got %h exp a5c3", deser_data_o); end
    n_vec++; if (deser_mod_o !== 4'd0) begin n_err++; $display("FAIL full_mod got %0d exp 0", deser_mod_o); end
    idle(1'b0);
    n_vec++; if (deser_data_val_o !== 1'b0) begin n_err++; $display("FAIL full_pulse_width got %b exp 0", deser_data_val_o); end
    n_vec++; if (deser_data_o !== 16'hA5C3) begin n_err++; $display("FAIL full_hold got %h exp a5c3", deser_data_o); end
    n_vec++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL full_pulses got %0d exp 1", pulse_cnt - p0); end
  endtask

  task automatic test_early_last();
    logic [4:0] bits;
    int p0;
    bits = 5'b10110;
    p0   = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      drive_bit(bits[4-i], (i == 4));
      n_vec++; if (deser_data_val_o !== (i == 4)) begin n_err++; $display("FAIL early_val bit %0d got %b exp %b", i, deser_data_val_o, (i == 4)); end
    end
    n_vec++; if (deser_data_o !== 16'hB000) begin n_err++; $display("FAIL early_data got %h exp b000", deser_data_o); end
    n_vec++; if (deser_mod_o !== 4'd5) begin n_err++; $display("FAIL early_mod got %0d exp 5", deser_mod_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL early_busy got %b exp 0", busy_o); end
    idle(1'b0);
    n_vec++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL early_pulses got %0d exp 1", pulse_cnt - p0); end
    n_vec++; if (deser_mod_o !== 4'd5) begin n_err++; $display("FAIL early_mod_hold got %0d exp 5", deser_mod_o); end
  endtask

  task automatic test_gaps();
    logic [15:0] w;
    int p0;
    w  = 16'h8001;
    p0 = pulse_cnt;
    for (int i = 0; i < 16; i++) begin
      drive_bit(w[15-i], 1'b0);
      if (i == 3 || i == 10) begin
        for (int g = 0; g < ((i == 3) ? 3 : 1); g++) begin
          idle(1'b0);
          n_vec++; if (deser_data_val_o !== 1'b0) begin n_err++; $display("FAIL gap_val after bit %0d got %b exp 0", i, deser_data_val_o); end
          n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL gap_busy after bit %0d got %b exp 1", i, busy_o); end
        end
      end
    end
    n_vec++; if (deser_data_val_o !== 1'b1) begin n_err++; $display("FAIL gap_end_val got %b exp 1", deser_data_val_o); end
    n_vec++; if (deser_data_o !== 16'h8001) begin n_err++; $display("FAIL gap_data got %h exp 8001", deser_data_o); end
    n_vec++; if (deser_mod_o !== 4'd0) begin n_err++; $display("FAIL gap_mod got %0d exp 0", deser_mod_o); end
    idle(1'b0);
    n_vec++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL gap_pulses got %0d exp 1", pulse_cnt - p0); end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < 16; i++) drive_bit(1'b1, 1'b0);
    n_vec++; if (deser_data_val_o !== 1'b1) begin n_err++; $display("FAIL b2b_w1_val got %b exp 1", deser_data_val_o); end
    n_vec++; if (deser_data_o !== 16'hFFFF) begin n_err++; $display("FAIL b2b_w1_data got %h exp ffff", deser_data_o); end
    n_vec++; if (deser_mod_o !== 4'd0) begin n_err++; $display("FAIL b2b_w1_mod got %0d exp 0", deser_mod_o); end
    drive_bit(1'b1, 1'b1);
    n_vec++; if (deser_data_val_o !== 1'b1) begin n_err++; $display("FAIL b2b_w2_val got %b exp 1", deser_data_val_o); end
    n_vec++; if (deser_data_o !== 16'h8000) begin n_err++; $display("FAIL b2b_w2_data got %h exp 8000", deser_data_o); end
    n_vec++; if (deser_mod_o !== 4'd1) begin n_err++; $display("FAIL b2b_w2_mod got %0d exp 1", deser_mod_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL b2b_w2_busy got %b exp 0", busy_o); end
    for (int i = 0; i < 16; i++) begin
      drive_bit(1'b0, 1'b0);
      if (i == 0) begin
        n_vec++; if (deser_data_val_o !== 1'b0) begin n_err++; $display("FAIL b2b_w3_start_val got %b exp 0", deser_data_val_o); end
        n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL b2b_w3_start_busy got %b exp 1", busy_o); end
      end
    end
    n_vec++; if (deser_data_val_o !== 1'b1) begin n_err++; $display("FAIL b2b_w3_val got %b exp 1", deser_data_val_o); end
    n_vec++; if (deser_data_o !== 16'h0000) begin n_err++; $display("FAIL b2b_w3_data got %h exp 0000", deser_data_o); end
    n_vec++; if (deser_mod_o !== 4'd0) begin n_err++; $display("FAIL b2b_w3_mod got %0d exp 0", deser_mod_o); end
    idle(1'b0);
    n_vec++; if (pulse_cnt - p0 !== 3) begin n_err++; $display("FAIL b2b_pulses got %0d exp 3", pulse_cnt - p0); end
  endtask

  task automatic test_reset_mid_word();
    logic [15:0] w;
    int p0;
    w  = 16'h1234;
    p0 = pulse_cnt;
    for (int i = 0; i < 7; i++) drive_bit(w[15-i], 1'b0);
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_pre got %b exp 1", busy_o); end
    srst_i = 1'b0;
    idle(1'b0);
    srst_i = 1'b1;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b exp 0", busy_o); end
    n_vec++; if (deser_data_o !== 16'h0000) begin n_err++; $display("FAIL rstmid_data_clr got %h exp 0000", deser_data_o); end
    for (int i = 0; i < 16; i++) drive_bit(w[15-i], 1'b0);
    n_vec++; if (deser_data_o !== 16'h1234) begin n_err++; $display("FAIL rstmid_data got %h exp 1234", deser_data_o); end
    n_vec++; if (deser_mod_o !== 4'd0) begin n_err++; $display("FAIL rstmid_mod got %0d exp 0", deser_mod_o); end
    idle(1'b0);
    n_vec++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL rstmid_pulses got %0d exp 1", pulse_cnt - p0); end
  endtask

  task automatic test_reset_collision();
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < 15; i++) drive_bit(1'b1, 1'b0);
    srst_i = 1'b0;
    drive_bit(1'b1, 1'b0);
    srst_i = 1'b1;
    n_vec++; if (deser_data_val_o !== 1'b0) begin n_err++; $display("FAIL rstcol_val got %b exp 0", deser_data_val_o); end
    n_vec++; if (deser_data_o !== 16'h0000) begin n_err++; $display("FAIL rstcol_data got %h exp 0000", deser_data_o); end
    idle(1'b0);
    n_vec++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("FAIL rstcol_pulses got %0d exp 0", pulse_cnt - p0); end
  endtask

  task automatic test_last_ignored();
    logic [15:0] w;
    int p0;
    w  = 16'h5A3C;
    p0 = pulse_cnt;
    for (int i = 0; i < 16; i++) begin
      drive_bit(w[15-i], (i == 15));
      if (i == 6) begin
        idle(1'b1);
        n_vec++; if (deser_data_val_o !== 1'b0) begin n_err++; $display("FAIL lastign_val got %b exp 0", deser_data_val_o); end
        n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL lastign_busy got %b exp 1", busy_o); end
      end
    end
    n_vec++; if (deser_data_val_o !== 1'b1) begin n_err++; $display("FAIL lastign_end_val got %b exp 1", deser_data_val_o); end
    n_vec++; if (deser_data_o !== 16'h5A3C) begin n_err++; $display("FAIL lastign_data got %h exp 5a3c", deser_data_o); end
    n_vec++; if (deser_mod_o !== 4'd0) begin n_err++; $display("FAIL lastign_mod got %0d exp 0", deser_mod_o); end
    idle(1'b0);
    idle(1'b0);
    n_vec++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL lastign_pulses got %0d exp 1", pulse_cnt - p0); end
  endtask

  // Scenario sequence.
  initial begin
    n_vec          = 0;
    n_err          = 0;
    pulse_cnt      = 0;
    srst_i         = 1'b0;
    ser_data_i     = 1'b0;
    ser_data_val_i = 1'b0;
    ser_last_i     = 1'b0;
    test_reset();
    test_full_word();
    test_early_last();
    test_gaps();
    test_back_to_back();
    test_reset_mid_word();
    test_reset_collision();
    test_last_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
